// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: zone codes, FSM states and load-limit default.
// The optional ISSUE_WB_BYPASS_EN macro lets same-cycle load writebacks relieve hazards.
package issue_ctrl_pkg;

    localparam int unsigned MAX_LOADS_DEFAULT = 4;
    localparam int unsigned ZONE_W = 2;

    typedef enum logic [ZONE_W-1:0] {
        ZONE_ALU,
        ZONE_LOADQ,
        ZONE_STORE,
        ZONE_CSR
    } zone_e;

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } issue_state_e;

    function automatic logic [31:0] reg_mask(input logic [4:0] addr);
        reg_mask = 32'd1 << addr;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register plus an outstanding-load count.
// A same-cycle set and clear of one register keeps the bit set and leaves the count unchanged.
module reg_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int unsigned C_MAX_LOADS = MAX_LOADS_DEFAULT,
    parameter int unsigned CntW        = $clog2(C_MAX_LOADS) + 1
) (
    input  logic            clk_i,
    input  logic            resetb_i,
    input  logic            set_i,
    input  logic [4:0]      set_addr_i,
    input  logic            clr_i,
    input  logic [4:0]      clr_addr_i,
    output logic [31:0]     pending_o,
    output logic [CntW-1:0] count_o
);

    logic [31:0]     pending_q, pending_d;
    logic [CntW-1:0] count_q, count_d;
    logic            clr_eff;

    // Writebacks with nothing outstanding are stray and dropped entirely.
    assign clr_eff = clr_i & (count_q != '0);

    always_comb begin
        pending_d = pending_q;
        if (clr_eff) begin
            pending_d = pending_d & ~reg_mask(clr_addr_i);
        end
        if (set_i) begin
            pending_d = pending_d | reg_mask(set_addr_i);
        end
        pending_d[0] = 1'b0;

        count_d = count_q;
        case ({set_i, clr_eff})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pending_o = pending_q;
    assign count_o   = count_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue stage controller: stalls on load-use/WAW hazards and the load limit, drains loads
// before serialising instructions. Define ISSUE_WB_BYPASS_EN to let same-cycle writebacks clear hazards.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int unsigned C_MAX_LOADS = MAX_LOADS_DEFAULT
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              ids_valid_i,
    output logic              ids_ready_o,
    input  logic              ins_err_i,
    input  logic [ZONE_W-1:0] zone_i,
    input  logic              csr_i,
    input  logic              regd_tgt_i,
    input  logic [4:0]        regd_addr_i,
    input  logic              regs1_rd_i,
    input  logic [4:0]        regs1_addr_i,
    input  logic              regs2_rd_i,
    input  logic [4:0]        regs2_addr_i,
    output logic              exs_valid_o,
    input  logic              exs_ready_i,
    input  logic              lq_wb_valid_i,
    input  logic [4:0]        lq_wb_addr_i,
    input  logic              flush_i,
    output logic [31:0]       pending_o
);

    localparam int unsigned CntW = $clog2(C_MAX_LOADS) + 1;

    logic [31:0]     pending_q;
    logic [CntW-1:0] count_q;
    logic [31:0]     pend_view;
    logic [CntW-1:0] count_view;
    issue_state_e    state_q, state_d;
    logic            exs_valid_q, exs_valid_d;
    logic            is_load, hazard, serialise, ready, issue, sb_set;

    reg_scoreboard #(
        .C_MAX_LOADS (C_MAX_LOADS),
        .CntW        (CntW)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .resetb_i   (resetb_i),
        .set_i      (sb_set),
        .set_addr_i (regd_addr_i),
        .clr_i      (lq_wb_valid_i),
        .clr_addr_i (lq_wb_addr_i),
        .pending_o  (pending_q),
        .count_o    (count_q)
    );

    // Scoreboard view used for hazard detection this cycle.
    always_comb begin
        pend_view  = pending_q;
        count_view = count_q;
`ifdef ISSUE_WB_BYPASS_EN
        if (lq_wb_valid_i && (count_q != '0)) begin
            pend_view  = pending_q & ~reg_mask(lq_wb_addr_i);
            count_view = count_q - CntW'(1);
        end
`endif
    end

    always_comb begin
        is_load = (zone_i == ZONE_LOADQ);
        hazard  = ~ins_err_i & ((regs1_rd_i & pend_view[regs1_addr_i])
                             | (regs2_rd_i & pend_view[regs2_addr_i])
                             | (regd_tgt_i & pend_view[regd_addr_i])
                             | (is_load & regd_tgt_i & (count_view == CntW'(C_MAX_LOADS))));
        // A serialising instruction must wait until every load has returned.
        serialise = (csr_i | ins_err_i) & (count_q != '0);
        ready     = resetb_i & ~flush_i & (state_q == StRun) & ~hazard & ~serialise
                  & (~exs_valid_q | exs_ready_i);
        issue     = ids_valid_i & ready;
        sb_set    = issue & is_load & regd_tgt_i & ~ins_err_i & (regd_addr_i != 5'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (ids_valid_i && serialise) state_d = StDrain;
            StDrain: if (count_q == '0) state_d = StRun;
            default: state_d = StRun;
        endcase
        if (flush_i) begin
            state_d = StRun;
        end

        exs_valid_d = exs_valid_q;
        if (issue) begin
            exs_valid_d = 1'b1;
        end else if (exs_ready_i || flush_i) begin
            exs_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q     <= StRun;
            exs_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exs_valid_q <= exs_valid_d;
        end
    end

    assign ids_ready_o = ready;
    assign exs_valid_o = exs_valid_q;
    assign pending_o   = pending_q;

endmodule
